// File: rtl/usb_eps_arb_pkg.sv
// Shared definitions for the endpoint-status RAM arbiter: default widths,
// tracking delay-line field positions and the owner encoding.
package usb_eps_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    // Tracking word layout: {valid, owner=B, is_read}
    localparam int EPSA_V  = 2;
    localparam int EPSA_B  = 1;
    localparam int EPSA_RD = 0;
    localparam int EPSA_W  = 3;

    typedef logic [EPSA_W-1:0] epsa_t;

    typedef enum logic {
        OWN_T = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    function automatic epsa_t epsa_pack(input logic valid, input owner_e owner, input logic is_read);
        epsa_t w;
        w          = '0;
        w[EPSA_V]  = valid;
        w[EPSA_B]  = (owner == OWN_B);
        w[EPSA_RD] = is_read;
        return w;
    endfunction

endpackage

// File: rtl/usb_eps_arb_if.sv
// Host-bus request/acknowledge channel into the endpoint-status arbiter.
interface usb_eps_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/usb_eps_arb.sv
// Shares the endpoint-status RAM between the transaction engine (absolute
// priority, fixed 3-cycle read latency) and the host bus (req/ack, idle slots only).
module usb_eps_arb
    import usb_eps_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              eps_read_0,
    input  logic              eps_zero_0,
    input  logic              eps_write_0,
    input  logic [ADDR_W-1:0] eps_addr_0,
    input  logic [DATA_W-1:0] eps_wrdata_0,
    output logic [DATA_W-1:0] eps_rddata_3,
    usb_eps_arb_if.slave      bus,
    output logic [ADDR_W-1:0] ram_addr_1,
    output logic [DATA_W-1:0] ram_wdata_1,
    output logic              ram_we_1,
    output logic              ram_re_1,
    input  logic [DATA_W-1:0] ram_rdata_2
);

    logic              t_wr, t_rd, t_act, b_gnt, b_ack;
    logic              b_busy_q, b_busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d, re_q, re_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;
    epsa_t             trk_q [1:3];
    epsa_t             trk_d [1:3];

    always_comb begin
        t_wr  = eps_write_0 | eps_zero_0;
        t_rd  = eps_read_0 & ~t_wr;
        t_act = t_wr | eps_read_0;
        b_gnt = bus.bus_req & ~b_busy_q & ~t_act;
        b_ack = trk_q[3][EPSA_V] & trk_q[3][EPSA_B];
    end

    // Issue mux: T always wins; enables drop when idle while address/data hold.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        trk_d[1] = '0;
        if (t_act) begin
            addr_d   = eps_addr_0;
            wdata_d  = eps_zero_0 ? '0 : eps_wrdata_0;
            we_d     = t_wr;
            re_d     = t_rd;
            trk_d[1] = epsa_pack(1'b1, OWN_T, t_rd);
        end else if (b_gnt) begin
            addr_d   = bus.bus_addr;
            wdata_d  = bus.bus_wdata;
            we_d     = bus.bus_we;
            re_d     = ~bus.bus_we;
            trk_d[1] = epsa_pack(1'b1, OWN_B, ~bus.bus_we);
        end
    end

    for (genvar gi = 2; gi <= 3; gi++) begin : g_trk
        assign trk_d[gi] = trk_q[gi-1];
    end

    always_comb begin
        b_busy_d = b_busy_q;
        if (b_gnt) begin
            b_busy_d = 1'b1;
        end else if (b_ack) begin
            b_busy_d = 1'b0;
        end
        // Only stage-2 reads load the shared data register, so writes never clobber it.
        rddata_d = (trk_q[2][EPSA_V] & trk_q[2][EPSA_RD]) ? ram_rdata_2 : rddata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_busy_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            rddata_q <= '0;
            for (int i = 1; i <= 3; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            b_busy_q <= b_busy_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            rddata_q <= rddata_d;
            for (int i = 1; i <= 3; i++) begin
                trk_q[i] <= trk_d[i];
            end
        end
    end

    assign ram_addr_1    = addr_q;
    assign ram_wdata_1   = wdata_q;
    assign ram_we_1      = we_q;
    assign ram_re_1      = re_q;
    assign eps_rddata_3  = rddata_q;
    assign bus.bus_rdata = rddata_q;
    assign bus.bus_ack   = b_ack;

endmodule

// File: tb/tb_usb_eps_arb.sv
// Scoreboard bench for usb_eps_arb: stimulus pushes expected T read data and
// B acknowledges (with due cycle); a negedge monitor pops and compares.
module tb_usb_eps_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        eps_read_0, eps_zero_0, eps_write_0;
    logic [7:0]  eps_addr_0;
    logic [15:0] eps_wrdata_0, eps_rddata_3;
    logic [7:0]  ram_addr_1;
    logic [15:0] ram_wdata_1, ram_rdata_2;
    logic        ram_we_1, ram_re_1;

    usb_eps_arb_if #(.ADDR_W(8), .DATA_W(16)) bif ();

    usb_eps_arb #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .eps_read_0   (eps_read_0),
        .eps_zero_0   (eps_zero_0),
        .eps_write_0  (eps_write_0),
        .eps_addr_0   (eps_addr_0),
        .eps_wrdata_0 (eps_wrdata_0),
        .eps_rddata_3 (eps_rddata_3),
        .bus          (bif.slave),
        .ram_addr_1   (ram_addr_1),
        .ram_wdata_1  (ram_wdata_1),
        .ram_we_1     (ram_we_1),
        .ram_re_1     (ram_re_1),
        .ram_rdata_2  (ram_rdata_2)
    );

    always #5 clk = ~clk;

    // Synchronous status RAM model
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_we_1) mem[ram_addr_1] <= ram_wdata_1;
        if (ram_re_1) ram_rdata_2 <= mem[ram_addr_1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    exp_t b_q[$];
    exp_t t_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   ack_cnt = 0;
    logic mon_en = 1'b0;

    // Monitor
    logic exp_ack;
    exp_t me;
    logic prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_ack = (b_q.size() > 0) && (b_q[0].due == cyc);
            checks++;
            if (bif.bus_ack !== exp_ack) begin
                fails++;
                $display("FAIL bus_ack cyc=%0d got=%b exp=%b", cyc, bif.bus_ack, exp_ack);
            end
            if (exp_ack) begin
                me = b_q.pop_front();
                if (me.rd) begin
                    checks++;
                    if (bif.bus_rdata !== me.data) begin
                        fails++;
                        $display("FAIL bus_rdata cyc=%0d got=%h exp=%h", cyc, bif.bus_rdata, me.data);
                    end
                end
                $display("B ack  cyc=%0d rd=%b rdata=%h", cyc, me.rd, bif.bus_rdata);
            end
            if (t_q.size() > 0 && t_q[0].due == cyc) begin
                me = t_q.pop_front();
                checks++;
                if (eps_rddata_3 !== me.data) begin
                    fails++;
                    $display("FAIL eps_rddata_3 cyc=%0d got=%h exp=%h", cyc, eps_rddata_3, me.data);
                end
                $display("T read cyc=%0d data=%h", cyc, eps_rddata_3);
            end
            if (bif.bus_ack === 1'b1) ack_cnt++;
            if (prev_req && !bif.bus_req && !prev_ack && rst_n && prev_rst) begin
                checks++;
                fails++;
                $display("FAIL bus_req_hold cyc=%0d got=dropped exp=held", cyc);
            end
        end
        prev_req = bif.bus_req;
        prev_ack = bif.bus_ack;
        prev_rst = rst_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic t_drive(input logic rd, input logic wr, input logic zr,
                           input logic [7:0] a, input logic [15:0] d, input logic [15:0] exp);
        exp_t e;
        eps_read_0   = rd;
        eps_write_0  = wr;
        eps_zero_0   = zr;
        eps_addr_0   = a;
        eps_wrdata_0 = d;
        if (rd && !(wr || zr)) begin
            e.due = cyc + 3; e.rd = 1'b1; e.data = exp;
            t_q.push_back(e);
        end
        step();
        eps_read_0  = 1'b0;
        eps_write_0 = 1'b0;
        eps_zero_0  = 1'b0;
    endtask

    task automatic bus_op(input logic we, input logic [7:0] a, input logic [15:0] wd,
                          input logic [15:0] exp, input int lat);
        exp_t e;
        bit   seen = 1'b0;
        e.due = cyc + lat; e.rd = ~we; e.data = exp;
        b_q.push_back(e);
        bif.bus_req   = 1'b1;
        bif.bus_we    = we;
        bif.bus_addr  = a;
        bif.bus_wdata = wd;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bif.bus_ack === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL bus_timeout addr=%h got=no_ack exp=ack", a);
        end
        step();
        bif.bus_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        eps_read_0 = 0; eps_zero_0 = 0; eps_write_0 = 0;
        eps_addr_0 = '0; eps_wrdata_0 = '0;
        bif.bus_req = 0; bif.bus_we = 0; bif.bus_addr = '0; bif.bus_wdata = '0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({ram_we_1, ram_re_1, ram_addr_1, ram_wdata_1, eps_rddata_3, bif.bus_ack} !== '0) begin
            fails++;
            $display("FAIL reset_state got=%b%b %h %h %h %b exp=all_zero",
                     ram_we_1, ram_re_1, ram_addr_1, ram_wdata_1, eps_rddata_3, bif.bus_ack);
        end
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        step();

        // Preload through the T port
        t_drive(0, 1, 0, 8'h15, 16'hBEEF, 0);
        t_drive(0, 1, 0, 8'h30, 16'hC0DE, 0);
        t_drive(0, 1, 0, 8'h40, 16'hFFFF, 0);
        for (int i = 0; i < 4; i++) t_drive(0, 1, 0, 8'h60 + 8'(i), 16'h1111 * 16'(i + 1), 0);
        step();

        // 1: T read latency
        t_drive(1, 0, 0, 8'h15, 0, 16'hBEEF);
        repeat (4) step();

        // 2: uncontended B write then read
        bus_op(1, 8'h20, 16'h1234, 0, 3);
        bus_op(0, 8'h20, 0, 16'h1234, 3);
        step();

        // 3: contention with 4 back-to-back T reads
        fork
            bus_op(0, 8'h30, 0, 16'hC0DE, 7);
            begin
                for (int i = 0; i < 4; i++) t_drive(1, 0, 0, 8'h60 + 8'(i), 0, 16'h1111 * 16'(i + 1));
            end
        join
        step();

        // 4: zero wins over read and ignores write data
        t_drive(1, 0, 1, 8'h40, 16'hAAAA, 0);
        @(negedge clk);
        checks++;
        if ({ram_we_1, ram_re_1, ram_wdata_1} !== {1'b1, 1'b0, 16'h0000}) begin
            fails++;
            $display("FAIL zero_issue got=we%b re%b wd%h exp=we1 re0 wd0000", ram_we_1, ram_re_1, ram_wdata_1);
        end
        step();
        t_drive(1, 0, 0, 8'h40, 0, 16'h0000);
        repeat (4) step();

        // 5: T write then B read of the same address one cycle later
        t_drive(0, 1, 0, 8'h50, 16'h5A5A, 0);
        bus_op(0, 8'h50, 0, 16'h5A5A, 3);
        step();

        // bus_ack coinciding with a new T read
        fork
            bus_op(0, 8'h20, 0, 16'h1234, 3);
            begin
                repeat (3) step();
                t_drive(1, 0, 0, 8'h15, 0, 16'hBEEF);
            end
        join
        repeat (4) step();

        // 6: reset one cycle after a B grant drops the operation
        bif.bus_req = 1'b1; bif.bus_we = 1'b0; bif.bus_addr = 8'h30;
        step();
        rst_n = 1'b0;
        bif.bus_req = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_we_1, ram_re_1, ram_addr_1, ram_wdata_1, eps_rddata_3, bif.bus_rdata, bif.bus_ack} !== '0) begin
            fails++;
            $display("FAIL reset_midop got=%b%b %h %h %h %h %b exp=all_zero", ram_we_1, ram_re_1,
                     ram_addr_1, ram_wdata_1, eps_rddata_3, bif.bus_rdata, bif.bus_ack);
        end
        begin
            int acks0;
            acks0 = ack_cnt;
            repeat (5) step();
            checks++;
            if (ack_cnt != acks0) begin
                fails++;
                $display("FAIL dropped_ack got=%0d exp=0 acks", ack_cnt - acks0);
            end
        end
        bus_op(0, 8'h30, 0, 16'hC0DE, 3);
        repeat (5) step();

        checks++;
        if (b_q.size() != 0 || t_q.size() != 0) begin
            fails++;
            $display("FAIL pending got=b%0d t%0d exp=b0 t0", b_q.size(), t_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
